// File: rtl/bp_pht_ctrl.sv
// bp_pht_ctrl: arbitrates a single-port pattern history table between
// fetch-stage lookups and execute-stage training. Training is a
// saturating 2-bit counter read-modify-write fed from a small FIFO so the
// execute stage never has to stall. After reset the whole table is swept
// to weakly-not-taken before any lookup is served.
module bp_pht_ctrl #(
    parameter int INDEX_BITS = 7,
    parameter int QDEPTH     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  lookup_valid_i,
    input  logic [INDEX_BITS-1:0] lookup_idx_i,
    output logic                  lookup_ready_o,
    output logic                  lookup_rvalid_o,
    output logic                  lookup_taken_o,

    input  logic                  train_valid_i,
    input  logic [INDEX_BITS-1:0] train_idx_i,
    input  logic                  train_taken_i,
    output logic                  train_ready_o,
    output logic                  train_drop_o,

    output logic                  init_busy_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [INDEX_BITS-1:0] mem_addr_o,
    output logic [1:0]            mem_wdata_o,
    input  logic [1:0]            mem_rdata_i
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(QDEPTH);
    localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
    localparam logic [1:0]            CNT_WNT  = 2'b01;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_TRAIN_RD,
        S_TRAIN_WR
    } state_e;

    state_e                  state_q, state_d;
    logic [INDEX_BITS-1:0]   init_cnt_q, init_cnt_d;

    // Training FIFO storage and bookkeeping
    logic [INDEX_BITS-1:0]   fifo_idx_q   [QDEPTH];
    logic                    fifo_taken_q [QDEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;

    // Train currently owning the RAM port
    logic [INDEX_BITS-1:0]   cur_idx_q, cur_idx_d;
    logic                    cur_taken_q, cur_taken_d;
    logic [1:0]              cur_cnt_q, cur_cnt_d;

    logic                    rvalid_q, rvalid_d;

    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [INDEX_BITS-1:0]   head_idx;
    logic                    head_taken;

    // Saturating counter step: taken counts up to 11, not-taken down to 00
    function automatic logic [1:0] satUpdate(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == FULL_CNT);
    assign head_idx      = fifo_idx_q[rd_ptr_q];
    assign head_taken    = fifo_taken_q[rd_ptr_q];

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens a slot early.
    assign train_ready_o = (count_q < FULL_CNT);
    assign push          = train_valid_i & train_ready_o;
    assign train_drop_o  = train_valid_i & ~train_ready_o;

    assign init_busy_o     = (state_q == S_INIT);
    assign lookup_rvalid_o = rvalid_q;
    assign lookup_taken_o  = rvalid_q & mem_rdata_i[1];

    // Port scheduler: sweep, lookup service, and the three-cycle train RMW
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        cur_idx_d      = cur_idx_q;
        cur_taken_d    = cur_taken_q;
        cur_cnt_d      = cur_cnt_q;
        rvalid_d       = 1'b0;
        pop            = 1'b0;
        lookup_ready_o = 1'b0;
        mem_en_o       = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = 2'b00;

        unique case (state_q)
            S_INIT: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = init_cnt_q;
                mem_wdata_o = CNT_WNT;
                init_cnt_d  = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (!fifo_empty && (fifo_full || !lookup_valid_i)) begin
                    pop         = 1'b1;
                    cur_idx_d   = head_idx;
                    cur_taken_d = head_taken;
                    mem_en_o    = 1'b1;
                    mem_addr_o  = head_idx;
                    state_d     = S_TRAIN_RD;
                end else begin
                    lookup_ready_o = 1'b1;
                    if (lookup_valid_i) begin
                        mem_en_o   = 1'b1;
                        mem_addr_o = lookup_idx_i;
                        rvalid_d   = 1'b1;
                    end
                end
            end

            S_TRAIN_RD: begin
                cur_cnt_d = mem_rdata_i;
                state_d   = S_TRAIN_WR;
            end

            S_TRAIN_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = cur_idx_q;
                mem_wdata_o = satUpdate(cur_cnt_q, cur_taken_q);
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Scheduler state, sweep counter and in-flight train registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            cur_idx_q   <= '0;
            cur_taken_q <= 1'b0;
            cur_cnt_q   <= 2'b00;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cur_idx_q   <= cur_idx_d;
            cur_taken_q <= cur_taken_d;
            cur_cnt_q   <= cur_cnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Training FIFO: push and pop may land in the same cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_idx_q[i]   <= '0;
                fifo_taken_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_idx_q[wr_ptr_q]   <= train_idx_i;
                fifo_taken_q[wr_ptr_q] <= train_taken_i;
                wr_ptr_q               <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// tb_bp_pht_ctrl: drives bp_pht_ctrl with directed and random traffic
// against a bench-side RAM, comparing every cycle with a behavioural model
// that tracks the table contents, the pending-train queue and port usage.
module tb_bp_pht_ctrl;

    localparam int IB    = 7;
    localparam int QD    = 2;
    localparam int DEPTH = 1 << IB;

    logic          clk;
    logic          rstN;
    logic          lookupValid;
    logic [IB-1:0] lookupIdx;
    logic          lookupReady;
    logic          lookupRvalid;
    logic          lookupTaken;
    logic          trainValid;
    logic [IB-1:0] trainIdx;
    logic          trainTaken;
    logic          trainReady;
    logic          trainDrop;
    logic          initBusy;
    logic          memEn;
    logic          memWe;
    logic [IB-1:0] memAddr;
    logic [1:0]    memWdata;
    logic [1:0]    memRdata;

    logic [1:0]    ram [DEPTH];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        bit taken;
    } train_t;

    // Reference model state
    int     pht [DEPTH];
    train_t pendQ[$];
    int     sweepIdx;
    int     portBusy;
    train_t curTrain;
    bit     rvalidExp;
    bit     takenExp;

    bp_pht_ctrl #(.INDEX_BITS(IB), .QDEPTH(QD)) dut (
        .clk_i           (clk),
        .rst_n_i         (rstN),
        .lookup_valid_i  (lookupValid),
        .lookup_idx_i    (lookupIdx),
        .lookup_ready_o  (lookupReady),
        .lookup_rvalid_o (lookupRvalid),
        .lookup_taken_o  (lookupTaken),
        .train_valid_i   (trainValid),
        .train_idx_i     (trainIdx),
        .train_taken_i   (trainTaken),
        .train_ready_o   (trainReady),
        .train_drop_o    (trainDrop),
        .init_busy_o     (initBusy),
        .mem_en_o        (memEn),
        .mem_we_o        (memWe),
        .mem_addr_o      (memAddr),
        .mem_wdata_o     (memWdata),
        .mem_rdata_i     (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM standing in for the PHT macro
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) ram[memAddr] <= memWdata;
            else       memRdata     <= ram[memAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, checks the
    // outputs against the model, advances the model, then waits for the
    // next falling edge.
    task automatic applyStimulus(input bit lv, input int li, input bit tv, input int ti, input bit tt);
        bit     expReady;
        bit     expTrainReady;
        bit     newRvalid;
        bit     newTaken;
        bit     eEn;
        bit     eWe;
        int     eAddr;
        int     eWdata;
        int     v;

        lookupValid = lv;
        lookupIdx   = IB'(li);
        trainValid  = tv;
        trainIdx    = IB'(ti);
        trainTaken  = tt;
        #1;

        expTrainReady = (pendQ.size() < QD);
        checkOutput("train_ready", 32'(trainReady), 32'(expTrainReady));
        checkOutput("train_drop", 32'(trainDrop), 32'(tv && !expTrainReady));
        checkOutput("init_busy", 32'(initBusy), 32'(sweepIdx < DEPTH));
        checkOutput("rvalid", 32'(lookupRvalid), 32'(rvalidExp));
        checkOutput("taken", 32'(lookupTaken), 32'(rvalidExp ? takenExp : 1'b0));

        expReady  = 1'b0;
        newRvalid = 1'b0;
        newTaken  = 1'b0;
        eEn = 0; eWe = 0; eAddr = 0; eWdata = 0;

        if (sweepIdx < DEPTH) begin
            eEn = 1; eWe = 1; eAddr = sweepIdx; eWdata = 1;
            pht[sweepIdx] = 1;
            sweepIdx++;
        end else if (portBusy == 2) begin
            portBusy = 1;
        end else if (portBusy == 1) begin
            v = pht[curTrain.idx];
            if (curTrain.taken) v = (v < 3) ? v + 1 : 3;
            else                v = (v > 0) ? v - 1 : 0;
            eEn = 1; eWe = 1; eAddr = curTrain.idx; eWdata = v;
            pht[curTrain.idx] = v;
            portBusy = 0;
        end else if (pendQ.size() > 0 && (pendQ.size() == QD || !lv)) begin
            curTrain = pendQ.pop_front();
            eEn = 1; eAddr = curTrain.idx;
            portBusy = 2;
        end else begin
            expReady = 1'b1;
            if (lv) begin
                eEn = 1; eAddr = li;
                newRvalid = 1'b1;
                newTaken  = (pht[li] >= 2);
            end
        end

        checkOutput("lookup_ready", 32'(lookupReady), 32'(expReady));
        checkOutput("mem_en", 32'(memEn), 32'(eEn));
        checkOutput("mem_we", 32'(memWe), 32'(eWe));
        checkOutput("mem_addr", 32'(memAddr), 32'(eAddr));
        checkOutput("mem_wdata", 32'(memWdata), 32'(eWdata));

        if (tv && expTrainReady) pendQ.push_back('{idx: ti, taken: tt});
        rvalidExp = newRvalid;
        takenExp  = newTaken;

        @(negedge clk);
    endtask

    // Asserts reset at a falling edge, checks the reset outputs, releases
    // two cycles later on a falling edge.
    task automatic doReset();
        rstN        = 1'b0;
        lookupValid = 1'b0;
        trainValid  = 1'b0;
        lookupIdx   = '0;
        trainIdx    = '0;
        trainTaken  = 1'b0;
        #1;
        checkOutput("rst_init_busy", 32'(initBusy), 32'd1);
        checkOutput("rst_lookup_ready", 32'(lookupReady), 32'd0);
        checkOutput("rst_train_ready", 32'(trainReady), 32'd1);
        checkOutput("rst_rvalid", 32'(lookupRvalid), 32'd0);
        checkOutput("rst_drop", 32'(trainDrop), 32'd0);
        pendQ.delete();
        sweepIdx  = 0;
        portBusy  = 0;
        rvalidExp = 1'b0;
        takenExp  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic randomTraffic(input int n, input int lvPct, input int tvPct, input int idxMax);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(99) < lvPct, $urandom_range(idxMax),
                          $urandom_range(99) < tvPct, $urandom_range(idxMax),
                          $urandom_range(1) == 1);
        end
    endtask

    initial begin
        rstN        = 1'b0;
        lookupValid = 1'b0;
        trainValid  = 1'b0;
        lookupIdx   = '0;
        trainIdx    = '0;
        trainTaken  = 1'b0;
        @(negedge clk);
        doReset();

        // Sweep with two trains pushed part way through, then drained
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 20)      applyStimulus(0, 0, 1, 9, 1);
            else if (i == 30) applyStimulus(0, 0, 1, 9, 1);
            else              applyStimulus(0, 0, 0, 0, 0);
        end
        idleCycles(8);
        applyStimulus(1, 9, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        // Saturate idx 5 upward, look it up, then drive it back down
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 5, 1);
            idleCycles(4);
        end
        applyStimulus(1, 5, 0, 0, 0);
        idleCycles(2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 5, 0);
            idleCycles(4);
        end
        applyStimulus(1, 5, 0, 0, 0);
        idleCycles(2);

        // Continuous lookups with one then two trains queued
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, $urandom_range(15), (i == 3) || (i == 10) || (i == 11) || (i == 12),
                          $urandom_range(15), $urandom_range(1) == 1);
        end

        randomTraffic(600, 80, 30, 15);
        randomTraffic(300, 90, 70, 7);
        randomTraffic(200, 40, 20, DEPTH - 1);
        idleCycles(10);

        // Reset part way through the sweep with trains queued
        doReset();
        for (int i = 0; i < 60; i++) begin
            if (i == 10 || i == 11) applyStimulus(0, 0, 1, 77, 1);
            else                    applyStimulus(0, 0, 0, 0, 0);
        end
        doReset();
        idleCycles(DEPTH + 10);
        randomTraffic(100, 70, 30, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
